byte_prgm_mem: RTL and testbench
================================

# byte_prgm_mem

Parametrised byte-addressable program memory with word-organised storage. It is the next generation of the team's 64x8 program store: word width, depth and address width are configurable, and the block adds a req/busy handshake, completion strobes, an out-of-range error and a sequenced erase. It sits between the loader or fetch unit and the program store, and all byte writes are done as read-modify-write on a full word.

## Interface
- WORD_BYTES, 4, bytes per storage word; must be a power of 2, at least 1.
- WORDS, 16, number of storage words.
- ADRS_W, 6, byte-address width; must satisfy 2^ADRS_W >= WORDS*WORD_BYTES.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- mode  in  1  0 = read byte, 1 = write byte; sampled with req.
- adrs  in  ADRS_W  byte address; word = adrs/WORD_BYTES, lane = adrs%WORD_BYTES.
- data  in  8  write byte; sampled with req.
- erase  in  1  start a full-array clear; sampled only in IDLE.
- busy  out  1  high while not in IDLE.
- out  out  8  read byte; holds its value until the next read completes.
- out_valid  out  1  one-cycle pulse when out is updated.
- done  out  1  one-cycle pulse when a write commits or an erase finishes.
- err  out  1  one-cycle pulse for an out-of-range access (word index >= WORDS).
- perr  out  1  parity error on a read; tied 0 unless the parity option is compiled in.

## Operation
- FSM states: IDLE, FETCH, MERGE, WB, RDOUT, ERASE.
- In IDLE:
  - erase=1 goes to ERASE, and erase has priority over a simultaneous req.
  - req=1 with mode=0 goes to FETCH, then RDOUT.
  - req=1 with mode=1 goes to FETCH, then MERGE, then WB.
- Request capture: adrs, mode and data are registered on acceptance. Input changes during busy are ignored, and req during busy is dropped with no queueing.
- FETCH: temp <= mem[word].
- MERGE: temp lane <= data.
- WB: mem[word] <= temp, done=1, return to IDLE.
- RDOUT: out <= temp lane, out_valid=1, return to IDLE.
- ERASE: a counter clears one word per cycle, from 0 to WORDS-1. On the last word, done=1 and the FSM returns to IDLE.
- Out of range: on acceptance, the FSM goes directly back to IDLE with err=1. Memory is unchanged and out is unchanged.
- Reset values: busy=0, out=0, out_valid=0, done=0, err=0, perr=0, state=IDLE, erase counter=0, temp=0.
- rst_n does not clear the array; only erase does.
- Reset during an operation aborts it:
  - a write asserted before the WB edge is not committed;
  - an aborted erase leaves the words already cleared at 0 and the rest unchanged.

## Timing
- A request is accepted at edge E0; busy is high from after E0.
- Read: temp loads at E1; out and out_valid are updated at E2, a latency of 2 cycles. busy falls after E2.
- Write: fetch at E1, merge at E2, commit and done at E3, a latency of 3 cycles. busy falls after E3.
- Erase: done is asserted after edge E0+WORDS, and busy is high for WORDS cycles.
- Error case: err is asserted after E0 and busy is never raised.
- The earliest next acceptance is the edge after busy falls.
- Coherency: a read accepted after a write's done sees the new byte.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- BYTE_PRGM_MEM_PARITY_EN defined:
  - each stored byte carries an even-parity bit, written in WB and set to 0 in ERASE;
  - RDOUT recomputes parity over the selected lane and pulses perr alongside out_valid on a mismatch.
- Not defined: no parity storage, and perr is held at 0.

## Test plan
- Reset, then erase (WORDS=16): busy is high for 16 cycles, done pulses once, and a read of address 0x3F returns out=0x00 with out_valid 2 cycles after acceptance.
- Write 0xA5 to address 5, then 0x3C to address 6: a read of address 5 returns 0xA5 and a read of address 6 returns 0x3C. A read of address 4 returns 0x00, showing the lane merge left other bytes intact.
- Assert req and erase together in IDLE: erase wins. A req pulsed while busy is dropped, with no out_valid or done caused by it.
- WORDS=12, ADRS_W=6, write 0x77 to address 0x30: err pulses after E0, busy stays 0, and a later read of address 0x00 is unaffected.
- Assert rst_n=0 in the MERGE state of a write of 0xFF to address 9: all outputs go to their reset values, and a later read of address 9 returns the old byte.
- With BYTE_PRGM_MEM_PARITY_EN defined: force a stored parity bit to flip through a hierarchical deposit, then read that byte; perr pulses with out_valid.

Source files
------------

// File: rtl/byte_prgm_mem_if.sv
// Request/response bundle between a loader or fetch unit and byte_prgm_mem.
interface byte_prgm_mem_if #(
  parameter int ADRS_W = 6
);
  logic              req;
  logic              mode;
  logic [ADRS_W-1:0] adrs;
  logic [7:0]        data;
  logic              erase;
  logic              busy;
  logic [7:0]        out;
  logic              out_valid;
  logic              done;
  logic              err;
  logic              perr;

  modport master (
    output req, mode, adrs, data, erase,
    input  busy, out, out_valid, done, err, perr
  );
  modport slave (
    input  req, mode, adrs, data, erase,
    output busy, out, out_valid, done, err, perr
  );
endinterface

// File: rtl/byte_prgm_mem.sv
// Byte-addressable program store, word-organised, byte writes done as read-modify-write.
// Optional per-byte even parity when BYTE_PRGM_MEM_PARITY_EN is defined.
module byte_prgm_mem_lane (
  input  logic [7:0] cur,
  input  logic [7:0] din,
  input  logic       sel,
  output logic [7:0] nxt
);
  assign nxt = sel ? din : cur;
endmodule

module byte_prgm_mem #(
  parameter int WORD_BYTES = 4,
  parameter int WORDS      = 16,
  parameter int ADRS_W     = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  byte_prgm_mem_if.slave bus
);
  localparam int LB  = $clog2(WORD_BYTES);
  localparam int LW  = (LB > 0) ? LB : 1;
  localparam int WIW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, MERGE, WB, RDOUT, ERASE} state_t;
  typedef struct packed {
    logic           mode;
    logic [WIW-1:0] word;
    logic [LW-1:0]  lane;
    logic [7:0]     data;
  } req_t;
  typedef logic [WORD_BYTES-1:0][7:0] word_t;

  state_t         state_q, state_d;
  req_t           rq_q, rq_d;
  word_t          mem [WORDS];
  word_t          temp_q, merged, wdata;
  logic [WIW-1:0] cnt_q, widx;
  logic [31:0]    wi_full;
  logic           in_range, accept, we;
  logic [7:0]     out_q;
  logic           ov_q, done_q, err_q, perr_q;
  logic           ov_d, done_d, err_d, perr_d, perr_chk;

  assign wi_full  = 32'(bus.adrs) >> LB;
  assign in_range = wi_full < 32'(WORDS);
  assign accept   = (state_q == IDLE) && bus.req && !bus.erase && in_range;

  always_comb begin
    rq_d.mode = bus.mode;
    rq_d.word = WIW'(wi_full);
    rq_d.lane = LW'(32'(bus.adrs) & (WORD_BYTES - 1));
    rq_d.data = bus.data;
  end

  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
    byte_prgm_mem_lane u_lane (
      .cur (temp_q[i]),
      .din (rq_q.data),
      .sel (rq_q.lane == LW'(i)),
      .nxt (merged[i])
    );
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ov_d    = 1'b0;
    perr_d  = 1'b0;
    we      = 1'b0;
    widx    = rq_q.word;
    wdata   = temp_q;
    case (state_q)
      IDLE: begin
        if (bus.erase)   state_d = ERASE;
        else if (bus.req) begin
          if (in_range)  state_d = FETCH;
          else           err_d   = 1'b1;
        end
      end
      FETCH: state_d = rq_q.mode ? MERGE : RDOUT;
      MERGE: state_d = WB;
      WB: begin
        we      = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      RDOUT: begin
        ov_d    = 1'b1;
        perr_d  = perr_chk;
        state_d = IDLE;
      end
      ERASE: begin
        we    = 1'b1;
        widx  = cnt_q;
        wdata = '0;
        if (cnt_q == WIW'(WORDS - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rq_q    <= '0;
      temp_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
      if (accept)             rq_q   <= rq_d;
      if (state_q == FETCH)   temp_q <= mem[rq_q.word];
      if (state_q == MERGE)   temp_q <= merged;
      if (state_q == RDOUT)   out_q  <= temp_q[rq_q.lane];
      if (state_q == ERASE)   cnt_q  <= (state_d == IDLE) ? '0 : cnt_q + 1'b1;
    end
  end

  // Array is deliberately outside reset: only erase clears it.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

`ifdef BYTE_PRGM_MEM_PARITY_EN
  logic [WORD_BYTES-1:0] par [WORDS];
  logic [WORD_BYTES-1:0] tpar_q, wpar;

  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) wpar[i] = ^wdata[i];
  end

  always_ff @(posedge clk) begin
    if (we) par[widx] <= wpar;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tpar_q <= '0;
    else if (state_q == FETCH)  tpar_q <= par[rq_q.word];
  end

  assign perr_chk = (^temp_q[rq_q.lane]) ^ tpar_q[rq_q.lane];
`else
  assign perr_chk = 1'b0;
`endif

  assign bus.busy      = (state_q != IDLE);
  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.perr      = perr_q;
endmodule

// File: tb/tb_byte_prgm_mem.sv
// Directed bench for byte_prgm_mem: a 16-word and a 12-word instance share stimulus via sel.
module tb_byte_prgm_mem;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req = 1'b0, mode = 1'b0, erase = 1'b0, sel = 1'b0;
  logic [5:0] adrs = '0;
  logic [7:0] data = '0;
  int         checks = 0, failures = 0;

  logic       busy, out_valid, done, err, perr;
  logic [7:0] out;

  byte_prgm_mem_if #(.ADRS_W(6)) i0 ();
  byte_prgm_mem_if #(.ADRS_W(6)) i1 ();

  assign i0.req   = req & ~sel;
  assign i0.erase = erase & ~sel;
  assign i0.mode  = mode;
  assign i0.adrs  = adrs;
  assign i0.data  = data;
  assign i1.req   = req & sel;
  assign i1.erase = erase & sel;
  assign i1.mode  = mode;
  assign i1.adrs  = adrs;
  assign i1.data  = data;

  assign busy      = sel ? i1.busy      : i0.busy;
  assign out       = sel ? i1.out       : i0.out;
  assign out_valid = sel ? i1.out_valid : i0.out_valid;
  assign done      = sel ? i1.done      : i0.done;
  assign err       = sel ? i1.err       : i0.err;
  assign perr      = sel ? i1.perr      : i0.perr;

  byte_prgm_mem #(.WORD_BYTES(4), .WORDS(16), .ADRS_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .bus(i0)
  );
  byte_prgm_mem #(.WORD_BYTES(4), .WORDS(12), .ADRS_W(6)) dut12 (
    .clk(clk), .rst_n(rst_n), .bus(i1)
  );

  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic start_req(input logic m, input logic [5:0] a, input logic [7:0] d);
    req = 1'b1; mode = m; adrs = a; data = d;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, output logic [7:0] o, output int lat, output logic pe);
    lat = -1; o = 8'hxx; pe = 1'bx;
    start_req(1'b0, a, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = k; o = out; pe = perr; break; end
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d, output int lat);
    lat = -1;
    start_req(1'b1, a, d);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic do_erase(output int bcnt, output int dcnt, output int dat, output int ocnt);
    bcnt = 0; dcnt = 0; dat = -1; ocnt = 0;
    erase = 1'b1;
    @(posedge clk); #1;
    erase = 1'b0; req = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (busy) bcnt++;
      if (done) begin dcnt++; dat = j; end
      if (out_valid) ocnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    checks++; if ({busy, out_valid, done, err, perr, out} !== 13'h0) begin
      failures++; $display("FAIL reset_outs16 act=%0h exp=0", {busy, out_valid, done, err, perr, out}); end
    sel = 1'b1;
    checks++; if ({busy, out_valid, done, err, perr, out} !== 13'h0) begin
      failures++; $display("FAIL reset_outs12 act=%0h exp=0", {busy, out_valid, done, err, perr, out}); end
    sel = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_erase();
    int b, d, da, oc, lat; logic [7:0] o; logic pe;
    do_erase(b, d, da, oc);
    checks++; if (b !== 16) begin failures++; $display("FAIL erase_busy act=%0d exp=16", b); end
    checks++; if (d !== 1)  begin failures++; $display("FAIL erase_done_cnt act=%0d exp=1", d); end
    checks++; if (da !== 16) begin failures++; $display("FAIL erase_done_at act=%0d exp=16", da); end
    sel = 1'b1;
    do_erase(b, d, da, oc);
    checks++; if (b !== 12 || da !== 12) begin
      failures++; $display("FAIL erase12 act=busy%0d/at%0d exp=12/12", b, da); end
    sel = 1'b0;
    do_read(6'h3F, o, lat, pe);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rd3f_lat act=%0d exp=2", lat); end
    checks++; if (o !== 8'h00) begin failures++; $display("FAIL rd3f_data act=%0h exp=00", o); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL ov_pulse act=ov%0b/busy%0b exp=0/0", out_valid, busy); end
  endtask

  task automatic test_write_merge();
    int lat; logic [7:0] o; logic pe;
    do_write(6'd5, 8'hA5, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_lat act=%0d exp=3", lat); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_fall act=%0b exp=0", busy); end
    do_write(6'd6, 8'h3C, lat);
    do_read(6'd5, o, lat, pe);
    checks++; if (o !== 8'hA5) begin failures++; $display("FAIL rd5 act=%0h exp=a5", o); end
    checks++; if (pe !== 1'b0) begin failures++; $display("FAIL rd5_perr act=%0b exp=0", pe); end
    do_read(6'd6, o, lat, pe);
    checks++; if (o !== 8'h3C) begin failures++; $display("FAIL rd6 act=%0h exp=3c", o); end
    do_read(6'd4, o, lat, pe);
    checks++; if (o !== 8'h00) begin failures++; $display("FAIL rd4 act=%0h exp=00", o); end
    do_read(6'd7, o, lat, pe);
    checks++; if (o !== 8'h00) begin failures++; $display("FAIL rd7 act=%0h exp=00", o); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] o; logic pe;
    do_write(6'h3F, 8'h81, lat);
    do_read(6'h3F, o, lat, pe);
    checks++; if (o !== 8'h81 || lat !== 2) begin
      failures++; $display("FAIL b2b_rd act=%0h/lat%0d exp=81/2", o, lat); end
    do_read(6'h3C, o, lat, pe);
    checks++; if (o !== 8'h00) begin failures++; $display("FAIL b2b_lane0 act=%0h exp=00", o); end
  endtask

  task automatic test_priority();
    int b, d, da, oc, lat, ov_cnt, dn_cnt; logic [7:0] o; logic pe;
    req = 1'b1; mode = 1'b1; adrs = 6'h10; data = 8'h11;
    do_erase(b, d, da, oc);
    checks++; if (b !== 16 || d !== 1 || oc !== 0) begin
      failures++; $display("FAIL prio_erase act=b%0d/d%0d/o%0d exp=16/1/0", b, d, oc); end
    do_read(6'h10, o, lat, pe);
    checks++; if (o !== 8'h00) begin failures++; $display("FAIL prio_rd10 act=%0h exp=00", o); end
    do_read(6'd5, o, lat, pe);
    checks++; if (o !== 8'h00) begin failures++; $display("FAIL prio_rd5 act=%0h exp=00", o); end
    do_write(6'd2, 8'h5A, lat);
    start_req(1'b0, 6'd2, 8'h00);
    req = 1'b1; mode = 1'b1; adrs = 6'd3; data = 8'hEE;
    @(posedge clk); #1;
    req = 1'b0; adrs = 6'd0;
    ov_cnt = 0; dn_cnt = 0; o = 8'hxx;
    for (int j = 0; j < 8; j++) begin
      if (out_valid) begin ov_cnt++; o = out; end
      if (done) dn_cnt++;
      @(posedge clk); #1;
    end
    checks++; if (ov_cnt !== 1 || dn_cnt !== 0) begin
      failures++; $display("FAIL drop_req act=ov%0d/done%0d exp=1/0", ov_cnt, dn_cnt); end
    checks++; if (o !== 8'h5A) begin failures++; $display("FAIL drop_rd2 act=%0h exp=5a", o); end
    do_read(6'd3, o, lat, pe);
    checks++; if (o !== 8'h00) begin failures++; $display("FAIL drop_rd3 act=%0h exp=00", o); end
  endtask

  task automatic test_range();
    int lat; logic [7:0] o; logic pe;
    sel = 1'b1;
    do_write(6'h00, 8'h42, lat);
    do_read(6'h00, o, lat, pe);
    start_req(1'b1, 6'h30, 8'h77);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL oor_e0 act=err%0b/busy%0b exp=1/0", err, busy); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out !== 8'h42) begin
      failures++; $display("FAIL oor_e1 act=err%0b/busy%0b/done%0b/out%0h exp=0/0/0/42", err, busy, done, out); end
    do_read(6'h00, o, lat, pe);
    checks++; if (o !== 8'h42) begin failures++; $display("FAIL oor_rd0 act=%0h exp=42", o); end
    do_write(6'h2F, 8'h99, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL top_wr_lat act=%0d exp=3", lat); end
    do_read(6'h2F, o, lat, pe);
    checks++; if (o !== 8'h99) begin failures++; $display("FAIL top_rd act=%0h exp=99", o); end
    start_req(1'b0, 6'h3F, 8'h00);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL oor_rd act=err%0b/busy%0b exp=1/0", err, busy); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out !== 8'h99) begin
      failures++; $display("FAIL oor_rd_out act=ov%0b/out%0h exp=0/99", out_valid, out); end
    sel = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat; logic [7:0] o; logic pe;
    do_write(6'd9, 8'h5E, lat);
    start_req(1'b1, 6'd9, 8'hFF);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checks++; if ({busy, out_valid, done, err, perr, out} !== 13'h0) begin
      failures++; $display("FAIL abort_outs act=%0h exp=0", {busy, out_valid, done, err, perr, out}); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(6'd9, o, lat, pe);
    checks++; if (o !== 8'h5E) begin failures++; $display("FAIL abort_rd9 act=%0h exp=5e", o); end
    do_write(6'h00, 8'h12, lat);
    do_write(6'h28, 8'h34, lat);
    erase = 1'b1;
    @(posedge clk); #1;
    erase = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL erabort_busy act=%0b exp=0", busy); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(6'h00, o, lat, pe);
    checks++; if (o !== 8'h00) begin failures++; $display("FAIL erabort_w0 act=%0h exp=00", o); end
    do_read(6'd9, o, lat, pe);
    checks++; if (o !== 8'h00) begin failures++; $display("FAIL erabort_w2 act=%0h exp=00", o); end
    do_read(6'h28, o, lat, pe);
    checks++; if (o !== 8'h34) begin failures++; $display("FAIL erabort_w10 act=%0h exp=34", o); end
  endtask

`ifdef BYTE_PRGM_MEM_PARITY_EN
  task automatic test_parity();
    int lat; logic [7:0] o; logic pe;
    do_write(6'd5, 8'hA5, lat);
    dut.par[1][1] = ~dut.par[1][1];
    do_read(6'd5, o, lat, pe);
    checks++; if (o !== 8'hA5 || pe !== 1'b1) begin
      failures++; $display("FAIL par_bad act=%0h/p%0b exp=a5/1", o, pe); end
    do_read(6'd6, o, lat, pe);
    checks++; if (pe !== 1'b0) begin failures++; $display("FAIL par_good act=%0b exp=0", pe); end
  endtask
`endif

  initial begin
    test_reset();
    test_erase();
    test_write_merge();
    test_back_to_back();
    test_priority();
    test_range();
    test_reset_abort();
`ifdef BYTE_PRGM_MEM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
